uart_tx_stream: RTL
===================

Name: uart_tx_stream

Overview:
- Serial transmitter stage directly downstream of the packet sender. Pulls bytes over the DataNext/DataReady handshake and shifts them out on TxD as 8N1/8N2 asynchronous serial, LSB first.
- A one-byte holding register is refilled while the current frame is on the wire, so a continuous stream runs with no idle gap between frames.
- Hardware flow control via an active-low clear-to-send input.

Parameters:
- CLKS_PER_BIT, 4, clocks per serial bit (for example 48 MHz / 12 Mbaud); legal range 2..65535.
- STOPBITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-low reset. Assertion clears all state immediately. Release is synchronised internally with a 2-flop synchroniser.
- DataVal  input  8  byte from the upstream sender; valid only while DataReady=1.
- DataReady  input  1  single-cycle strobe from upstream: DataVal is valid this cycle.
- DataNext  output  1  registered request to upstream for the next byte.
- cts_n  input  1  clear-to-send, active low. Sampled through a 2-flop synchroniser.
- TxD  output  1  serial line; idles high.
- Busy  output  1  high while a frame is on the wire or the holding register is full.
- ProtoErr  output  1  sticky flag: DataReady was seen while DataNext=0. Cleared only by reset.

Behaviour:
- Reset values: TxD=1, DataNext=0, Busy=0, ProtoErr=0, holding register empty, FSM in IDLE, baud counter 0, bit index 0.
- Handshake:
  - DataNext is set on the clock after the holding register becomes empty, and is not set during reset.
  - When DataReady=1 is sampled while DataNext=1: the holding register captures DataVal, is marked full, and DataNext is cleared on that same edge. This guarantees the upstream block sees DataNext low on the following cycle and issues exactly one byte per request.
  - DataReady=1 while DataNext=0: the byte is discarded and ProtoErr is set.
- FSM states: IDLE, START, DATA, STOP. The baud counter reloads to CLKS_PER_BIT-1 at each bit start; a bit ends when the counter reaches 0.
  - IDLE: TxD=1. If the holding register is full and the synchronised cts_n=0: load the shift register, mark the holding register empty, go to START. TxD=0 from the next cycle.
  - START: TxD=0 for CLKS_PER_BIT clocks, then go to DATA with bit index 0.
  - DATA: TxD=shift[0] for CLKS_PER_BIT clocks per bit, shift right after each bit. After bit index 7 go to STOP.
  - STOP: TxD=1 for STOPBITS*CLKS_PER_BIT clocks. On the last clock:
    - if the holding register is full and cts_n=0, load it and go straight to START, so the start bit immediately follows the stop period;
    - otherwise go to IDLE.
- Latency: with the FSM in IDLE and DataNext=1, if DataReady is high in cycle n, TxD is first low in cycle n+2.
- Frame length: exactly (9+STOPBITS)*CLKS_PER_BIT clocks. Back-to-back frame period is the same value with zero idle clocks, provided upstream responds within 9*CLKS_PER_BIT clocks of a request.
- Flow control:
  - cts_n going high never truncates a frame in progress.
  - It only blocks the next frame start (IDLE->START or STOP->START).
  - The holding register may still be filled while cts_n=1.
- Busy = (state != IDLE) OR holding register full.
- Reset mid-frame: TxD returns to 1 immediately (asynchronous) and the held byte is lost. After reset release, DataNext reasserts within 3 clocks (2 synchroniser clocks plus 1).
- Arithmetic: the baud counter width is clog2(CLKS_PER_BIT). The stop counter covers STOPBITS*CLKS_PER_BIT. No overflow is possible within the legal parameter ranges.

Test Plan:
- Single byte (CLKS_PER_BIT=4, STOPBITS=1): drive 0xA5 with DataReady in cycle n.
  - TxD from cycle n+2 is 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks (40 clocks total).
  - DataNext is low from cycle n+1 and high again at n+2.
- Back-to-back stream: upstream answers every DataNext 1 clock later with bytes 0x00, 0xFF, 0x55.
  - Three frames with start bits exactly 40 clocks apart, no idle clocks.
  - Decoded bytes are identical to those sent.
- STOPBITS=2, byte 0x7F: stop level lasts 8 clocks; frame length is 44 clocks; the next start bit follows immediately.
- Flow control: raise cts_n mid-DATA of byte 0x3C while the holding register holds 0x81.
  - 0x3C completes; TxD then stays 1 and Busy=1.
  - Lower cts_n: 0x81 starts 3 clocks later (2 synchroniser clocks plus 1).
- Protocol error: pulse DataReady with DataVal=0x12 while DataNext=0.
  - ProtoErr=1 and stays high; 0x12 is never transmitted.
- Reset mid-frame: assert rst during bit 4 of 0xF0.
  - TxD=1, Busy=0, DataNext=0 immediately.
  - After release, DataNext=1 within 3 clocks; the next byte is transmitted cleanly.

Source files
------------

// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - 8N1/8N2 serial transmitter fed by a one-byte request/strobe handshake
module uart_tx_stream #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOPBITS     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] DataVal,
  input  logic       DataReady,
  output logic       DataNext,
  input  logic       cts_n,
  output logic       TxD,
  output logic       Busy,
  output logic       ProtoErr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int SW = $clog2(STOPBITS * CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOPBITS * CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    rst_sync;
  logic [1:0]    cts_sync;
  logic [7:0]    hold;
  logic          hold_full;
  logic          hold_full_next;
  logic [7:0]    shift;
  logic [CW-1:0] cnt;
  logic [SW-1:0] stop_cnt;
  logic [2:0]    bit_idx;

  logic rst_ok;
  logic cts_ok;
  logic can_start;
  logic bit_end;
  logic stop_end;
  logic last_bit;
  logic capture;
  logic load;

  assign rst_ok    = rst_sync[1];
  assign cts_ok    = ~cts_sync[1];
  assign can_start = hold_full & cts_ok;
  assign bit_end   = (cnt == '0);
  assign stop_end  = (stop_cnt == '0);
  assign last_bit  = (bit_idx == 3'd7);
  assign capture   = DataReady & DataNext;

  // Release of the asynchronous reset is re-timed so requests start cleanly after it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  // Clear-to-send comes from another domain; it resets to "not clear" until sampled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cts_sync <= 2'b11;
    end else begin
      cts_sync <= {cts_sync[0], cts_n};
    end
  end

  // Holding register occupancy after this edge: filled by a handshake, emptied by a frame load
  always_comb begin
    hold_full_next = hold_full;
    if (capture) begin
      hold_full_next = 1'b1;
    end else if (load) begin
      hold_full_next = 1'b0;
    end
  end

  // Upstream handshake: capture one byte per request, re-request as soon as the slot frees
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      DataNext  <= 1'b0;
      ProtoErr  <= 1'b0;
    end else begin
      if (capture) begin
        hold <= DataVal;
      end
      hold_full <= hold_full_next;
      DataNext  <= rst_ok & ~hold_full_next;
      if (DataReady & ~DataNext) begin
        ProtoErr <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; a frame load is allowed from IDLE or on the last stop clock
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (can_start) begin
          state_next = START;
          load       = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end && last_bit) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (stop_end) begin
          if (can_start) begin
            state_next = START;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM outputs: line level per state and occupancy flag
  always_comb begin
    TxD = 1'b1;
    case (state)
      IDLE:    TxD = 1'b1;
      START:   TxD = 1'b0;
      DATA:    TxD = shift[0];
      STOP:    TxD = 1'b1;
      default: TxD = 1'b1;
    endcase
    Busy = (state != IDLE) | hold_full;
  end

  // Bit timing and shifting; counters reload at every bit start and expire at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift    <= '0;
      cnt      <= '0;
      stop_cnt <= '0;
      bit_idx  <= '0;
    end else if (load) begin
      shift   <= hold;
      cnt     <= BIT_LAST;
      bit_idx <= '0;
    end else begin
      case (state)
        START: begin
          if (bit_end) begin
            cnt     <= BIT_LAST;
            bit_idx <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            cnt     <= BIT_LAST;
            if (last_bit) begin
              stop_cnt <= STOP_LAST;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (!stop_end) begin
            stop_cnt <= stop_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
